// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame master.
// The master runs mode 3; sampling polarity is derived from CPOL/CPHA.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } spi_state_e;

    localparam logic CPOL = 1'b1;
    localparam logic CPHA = 1'b1;

    // SCLK level reached by the edge on which MISO is sampled (high for mode 3)
    localparam logic SAMPLE_LEVEL = CPOL ~^ CPHA;

    localparam int DEFAULT_SIZE    = 40;
    localparam int DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/spi_halfperiod_tick.sv
// Restartable half-period timer: one-cycle tick every CLK_DIV cycles,
// held at phase zero while clear_in is high so SCLK aligns to CS_N.
module spi_halfperiod_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        tick_out = 1'b0;
        if (clear_in) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            tick_out = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// Frame-level SPI master (mode 3): shifts one SIZE-bit word out on MOSI while
// capturing MISO, framing each transfer with CS_N lead, trail and gap times.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int SIZE    = DEFAULT_SIZE,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [SIZE-1:0] data_in,
    input  logic            valid_in,
    output logic            ready_out,
    output logic [SIZE-1:0] data_out,
    output logic            done_out,
    output logic            sclk_out,
    output logic            mosi_out,
    input  logic            miso_in,
    output logic            cs_n_out
);

    localparam int BIT_W = $clog2(SIZE + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SIZE - 1);

    spi_state_e       state_q, state_d;
    logic [SIZE-1:0]  tx_shift_q, tx_shift_d;
    logic [SIZE-1:0]  rx_shift_q, rx_shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SIZE-1:0]  data_q, data_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             tick;

    // Timer is parked while idle so the first tick lands exactly D cycles after accept
    spi_halfperiod_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear_in (state_q == IDLE),
        .tick_out (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    tx_shift_d = data_in;
                    bit_cnt_d  = '0;
                    cs_n_d     = 1'b0;
                    state_d    = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_d  = ~CPOL;
                    mosi_d  = tx_shift_q[SIZE-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sclk_q != SAMPLE_LEVEL) begin
                        rx_shift_d = {rx_shift_q[SIZE-2:0], miso_in};
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = TRAIL;
                        end
                    end else begin
                        tx_shift_d = {tx_shift_q[SIZE-2:0], 1'b0};
                        mosi_d     = tx_shift_q[SIZE-2];
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    data_d  = rx_shift_q;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign data_out  = data_q;
    assign done_out  = done_q;
    assign sclk_out  = sclk_q;
    assign mosi_out  = mosi_q;
    assign cs_n_out  = cs_n_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: an 8-bit/div-2 and a 40-bit/div-1 instance share
// stimulus; a bus monitor turns the selected instance's pins into frame records.
module tb_spi_frame_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        miso_in = 1'b0;
    logic        sel40 = 1'b0;

    logic        ready8, done8, sclk8, mosi8, cs8;
    logic [7:0]  dout8;
    logic        ready40, done40, sclk40, mosi40, cs40;
    logic [39:0] dout40;

    logic        ready, done, sclk, mosi, cs;
    logic [39:0] dout;
    int          cur_size;
    int          cur_div;

    always #5 clk = ~clk;

    spi_frame_master #(.SIZE(8), .CLK_DIV(2)) dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data_in[7:0]), .valid_in(valid_in),
        .ready_out(ready8), .data_out(dout8), .done_out(done8), .sclk_out(sclk8),
        .mosi_out(mosi8), .miso_in(miso_in), .cs_n_out(cs8)
    );

    spi_frame_master #(.SIZE(40), .CLK_DIV(1)) dut40 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready40), .data_out(dout40), .done_out(done40), .sclk_out(sclk40),
        .mosi_out(mosi40), .miso_in(miso_in), .cs_n_out(cs40)
    );

    assign ready    = sel40 ? ready40 : ready8;
    assign done     = sel40 ? done40  : done8;
    assign sclk     = sel40 ? sclk40  : sclk8;
    assign mosi     = sel40 ? mosi40  : mosi8;
    assign cs       = sel40 ? cs40    : cs8;
    assign dout     = sel40 ? dout40  : {32'b0, dout8};
    assign cur_size = sel40 ? 40 : 8;
    assign cur_div  = sel40 ? 1 : 2;

    typedef struct {
        logic [39:0] mosi;
        int          rises;
        int          cs_len;
        logic        done_at_rise;
        logic [39:0] data;
    } frame_t;

    frame_t      frames[$];
    frame_t      cur_frame;
    int          tests = 0;
    int          fails = 0;
    int          done_count = 0;
    int          cs_falls = 0;
    int          rises = 0;
    int          cs_len = 0;
    int          high_run = 1000;
    int          last_gap = 0;
    logic        prev_sclk = 1'b1;
    logic        prev_cs = 1'b1;
    logic [39:0] mosi_acc = '0;
    logic [39:0] miso_word = '0;

    // Slave model and bus monitor: samples on the falling clk edge, presents the
    // next MISO bit while SCLK is high, and closes a frame record when CS_N rises.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sclk = 1'b1;
            prev_cs   = 1'b1;
            rises     = 0;
            cs_len    = 0;
            mosi_acc  = '0;
            miso_in   = 1'b0;
        end else begin
            if (done) done_count++;
            if (!cs) begin
                if (prev_cs) begin
                    cs_falls++;
                    last_gap = high_run;
                end
                cs_len++;
                if (!prev_sclk && sclk) begin
                    mosi_acc = {mosi_acc[38:0], mosi};
                    rises++;
                end
                miso_in = (rises < cur_size) ? miso_word[cur_size-1-rises] : 1'b0;
            end else if (!prev_cs) begin
                cur_frame.mosi         = mosi_acc;
                cur_frame.rises        = rises;
                cur_frame.cs_len       = cs_len;
                cur_frame.done_at_rise = done;
                cur_frame.data         = dout;
                frames.push_back(cur_frame);
                rises    = 0;
                cs_len   = 0;
                mosi_acc = '0;
                high_run = 1;
                miso_in  = 1'b0;
            end else begin
                high_run++;
            end
            prev_sclk = sclk;
            prev_cs   = cs;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitFalls(input int target, input string tag);
        int budget = 0;
        while (cs_falls < target && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({tag, "_start_timeout"}, 64'(cs_falls >= target), 64'd1);
    endtask

    task automatic waitFrames(input int target, input string tag);
        int budget = 0;
        while (frames.size() < target && budget < 600) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({tag, "_end_timeout"}, 64'(frames.size() >= target), 64'd1);
    endtask

    // Reference: MSB-first word on MOSI, SIZE rises, CS_N low (2*SIZE+1)*D cycles,
    // done coincident with CS_N rising and data_out equal to the MISO word.
    task automatic checkFrame(input int idx, input logic [39:0] word, input logic [39:0] miso,
                              input string tag);
        logic [39:0] mask;
        mask = (cur_size == 40) ? {40{1'b1}} : 40'hFF;
        if (idx < frames.size()) begin
            checkOutput({tag, "_mosi"},   frames[idx].mosi & mask, word & mask);
            checkOutput({tag, "_rises"},  frames[idx].rises, cur_size);
            checkOutput({tag, "_cs_len"}, frames[idx].cs_len, (2 * cur_size + 1) * cur_div);
            checkOutput({tag, "_done"},   frames[idx].done_at_rise, 1);
            checkOutput({tag, "_data"},   frames[idx].data, miso & mask);
        end
    endtask

    task automatic applyStimulus(input logic [39:0] word, input logic [39:0] miso, input string tag);
        int n0 = frames.size();
        int f0 = cs_falls;
        int d0 = done_count;
        miso_word = miso;
        @(negedge clk);
        data_in  = word;
        valid_in = 1'b1;
        waitFalls(f0 + 1, tag);
        valid_in = 1'b0;
        data_in  = 40'($urandom());
        waitFrames(n0 + 1, tag);
        repeat (2) @(negedge clk);
        checkFrame(n0, word, miso, tag);
        checkOutput({tag, "_done_pulses"}, done_count - d0, 1);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0, f0, d0, budget;
        logic [39:0] w;

        // reset with random inputs on the pins
        repeat (3) begin
            @(negedge clk);
            data_in  = {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF;
            valid_in = 1'($urandom());
        end
        for (int s = 0; s < 2; s++) begin
            sel40 = (s == 1);
            #1;
            checkOutput("rst_cs", cs, 1);
            checkOutput("rst_sclk", sclk, 1);
            checkOutput("rst_mosi", mosi, 0);
            checkOutput("rst_ready", ready, 1);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_data", dout, 0);
        end
        sel40 = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(40'hA5, 40'h3C, "single");

        // back-to-back with valid held high
        n0 = frames.size();
        f0 = cs_falls;
        d0 = done_count;
        miso_word = 40'h96;
        @(negedge clk);
        data_in  = 40'h01;
        valid_in = 1'b1;
        waitFalls(f0 + 1, "b2b_a");
        data_in = 40'h80;
        waitFalls(f0 + 2, "b2b_b");
        valid_in = 1'b0;
        checkOutput("b2b_gap_ge2", 64'(last_gap >= 2), 1);
        waitFrames(n0 + 2, "b2b");
        repeat (2) @(negedge clk);
        checkFrame(n0, 40'h01, 40'h96, "b2b_f1");
        checkFrame(n0 + 1, 40'h80, 40'h96, "b2b_f2");
        checkOutput("b2b_done_pulses", done_count - d0, 2);

        // busy interference: valid toggling and data_in=FF while the frame runs
        n0 = frames.size();
        f0 = cs_falls;
        miso_word = 40'hC3;
        @(negedge clk);
        data_in  = 40'h0F;
        valid_in = 1'b1;
        waitFalls(f0 + 1, "busy");
        budget = 0;
        while (!cs && budget < 200) begin
            data_in  = 40'hFF;
            valid_in = 1'($urandom());
            @(negedge clk);
            budget++;
        end
        valid_in = 1'b0;
        waitFrames(n0 + 1, "busy");
        repeat (12) @(negedge clk);
        checkFrame(n0, 40'h0F, 40'hC3, "busy");
        checkOutput("busy_one_frame", cs_falls - f0, 1);

        // reset after the fourth rising SCLK edge
        f0 = cs_falls;
        n0 = frames.size();
        miso_word = 40'h5C;
        @(negedge clk);
        data_in  = 40'($urandom_range(1, 255));
        valid_in = 1'b1;
        waitFalls(f0 + 1, "midrst");
        valid_in = 1'b0;
        budget = 0;
        while (rises < 4 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("midrst_reach4", 64'(budget < 200), 1);
        d0 = done_count;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_cs", cs, 1);
        checkOutput("midrst_sclk", sclk, 1);
        checkOutput("midrst_mosi", mosi, 0);
        checkOutput("midrst_ready", ready, 1);
        checkOutput("midrst_data", dout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_done", done_count - d0, 0);
        checkOutput("midrst_no_frame", frames.size() - n0, 0);
        applyStimulus(40'h5A, 40'($urandom_range(0, 255)), "after_rst");

        for (int i = 0; i < 4; i++) begin
            w = 40'($urandom_range(0, 255));
            applyStimulus(w, 40'($urandom_range(0, 255)), "rand8");
        end

        // extremes on the 40-bit, divide-by-one instance
        pulseReset();
        sel40 = 1'b1;
        repeat (2) @(negedge clk);
        n0 = frames.size();
        applyStimulus(40'h80_0000_0001, {40{1'b1}}, "ext");
        if (n0 < frames.size()) begin
            checkOutput("ext_first_bit", frames[n0].mosi[39], 1);
            checkOutput("ext_last_bit", frames[n0].mosi[0], 1);
        end
        for (int i = 0; i < 2; i++) begin
            w = {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF;
            applyStimulus(w, {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF, "rand40");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
